pov_column_scanner: RTL and testbench



---
 rtl/pov_column_scanner_if.sv | 39 +++
 rtl/pov_column_scanner.sv | 231 +++++++++++++++++++++++
 tb/tb_pov_column_scanner.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pov_column_scanner_if.sv
// Column write port and LED-side outputs of the POV column scanner.
// loop_en exists only when POV_LOOP_EN is defined.
interface pov_column_scanner_if #(
  parameter int ROWS  = 8,
  parameter int DEPTH = 16
);
  logic [ROWS-1:0]              input_pattern;
  logic                         glyph_end;
  logic                         col_valid;
  logic                         col_ready;
  logic [ROWS-1:0]              leds;
  logic                         col_strobe;
  logic                         busy;
  logic                         underflow;
  logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef POV_LOOP_EN
  logic                         loop_en;

  modport master (
    output input_pattern, glyph_end, col_valid, loop_en,
    input  col_ready, leds, col_strobe, busy, underflow, count
  );

  modport slave (
    input  input_pattern, glyph_end, col_valid, loop_en,
    output col_ready, leds, col_strobe, busy, underflow, count
  );
`else
  modport master (
    output input_pattern, glyph_end, col_valid,
    input  col_ready, leds, col_strobe, busy, underflow, count
  );

  modport slave (
    input  input_pattern, glyph_end, col_valid,
    output col_ready, leds, col_strobe, busy, underflow, count
  );
`endif
endinterface

// File: rtl/pov_column_scanner.sv
// Column FIFO plus tick-paced display FSM driving the LED rows of a POV stick.
// Define POV_LOOP_EN to add loop_en: the stored message then repeats instead of draining.
module pov_column_scanner #(
  parameter int ROWS      = 8,
  parameter int DEPTH     = 16,
  parameter int COL_TICKS = 4,
  parameter int GAP_COLS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  pov_column_scanner_if.slave  col_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (COL_TICKS > 1) ? $clog2(COL_TICKS) : 1;
  localparam int GW = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pov_column_scanner: DEPTH must be a power of two >= 2");
    end
    if (COL_TICKS < 1) begin : g_bad_ticks
      $error("pov_column_scanner: COL_TICKS must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic            glyph_end;
    logic [ROWS-1:0] pattern;
  } column_t;

  column_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   presc_q;

  state_e          state_q;
  logic [ROWS-1:0] leds_q;
  logic            shown_end_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            underflow_q;
  logic            strobe_q;
  logic            busy_q;

  logic            tick;
  logic            empty;
  logic            full;
  logic            push;
  logic            fetch;
  logic            free;
  logic            loop_active;
  logic            loop_fall;
  logic [AW-1:0]   fetch_ptr;
  column_t         fetch_col;

  assign tick  = (presc_q == PW'(COL_TICKS - 1));
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = col_if.col_valid && !full;

  // Free-running column-period prescaler; phase restarts only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    fetch = 1'b0;
    if (tick && !empty) begin
      case (state_q)
        IDLE:    fetch = 1'b1;
        SHOW:    fetch = !(shown_end_q && (GAP_COLS > 0));
        GAP:     fetch = (gap_cnt_q == '0);
        default: fetch = 1'b0;
      endcase
    end
  end

`ifdef POV_LOOP_EN
  logic          loop_q;
  logic [AW-1:0] disp_ptr_q, disp_ptr_d;
  logic [AW-1:0] disp_next;

  assign loop_active = col_if.loop_en;
  assign loop_fall   = loop_q && !col_if.loop_en;
  assign free        = fetch && !col_if.loop_en;
  assign fetch_ptr   = col_if.loop_en ? disp_ptr_q : rd_ptr_q;
  assign disp_next   = disp_ptr_q + 1'b1;

  // While looping the display pointer replays rd_ptr..wr_ptr-1; otherwise it shadows rd_ptr.
  always_comb begin
    disp_ptr_d = rd_ptr_d;
    if (col_if.loop_en && !loop_fall) begin
      disp_ptr_d = disp_ptr_q;
      if (fetch) begin
        disp_ptr_d = (disp_next == wr_ptr_q) ? rd_ptr_q : disp_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loop_q     <= 1'b0;
      disp_ptr_q <= '0;
    end else begin
      loop_q     <= col_if.loop_en;
      disp_ptr_q <= disp_ptr_d;
    end
  end
`else
  assign loop_active = 1'b0;
  assign loop_fall   = 1'b0;
  assign free        = fetch;
  assign fetch_ptr   = rd_ptr_q;
`endif

  assign fetch_col = mem_q[fetch_ptr];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (free) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, free})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Leaving loop mode discards everything, including a same-cycle write.
    if (loop_fall) begin
      rd_ptr_d = wr_ptr_d;
      count_d  = '0;
    end
  end

  // NOTE: storage is not reset; entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= column_t'{glyph_end: col_if.glyph_end, pattern: col_if.input_pattern};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      leds_q      <= '0;
      shown_end_q <= 1'b0;
      gap_cnt_q   <= '0;
      underflow_q <= 1'b0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      strobe_q <= tick;
      if (loop_fall) begin
        state_q <= IDLE;
        leds_q  <= '0;
        busy_q  <= 1'b0;
      end else if (tick) begin
        if (fetch) begin
          state_q     <= SHOW;
          leds_q      <= fetch_col.pattern;
          shown_end_q <= fetch_col.glyph_end;
          busy_q      <= 1'b1;
        end else begin
          case (state_q)
            SHOW: begin
              leds_q <= '0;
              if (shown_end_q && (GAP_COLS > 0)) begin
                state_q   <= GAP;
                gap_cnt_q <= GW'(GAP_COLS - 1);
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (!loop_active) underflow_q <= 1'b1;
              end
            end
            GAP: begin
              if (gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
            default: begin
              state_q <= IDLE;
              leds_q  <= '0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign col_if.col_ready  = !full;
  assign col_if.leds       = leds_q;
  assign col_if.col_strobe = strobe_q;
  assign col_if.busy       = busy_q;
  assign col_if.underflow  = underflow_q;
  assign col_if.count      = count_q;

endmodule

// File: tb/tb_pov_column_scanner.sv
// Self-checking bench: stimulus tables, directed corner sequences and random traffic
// compared every cycle against a queue-based model of the column scanner.
module tb_pov_column_scanner;

  localparam int ROWS      = 8;
  localparam int DEPTH     = 16;
  localparam int COL_TICKS = 4;
  localparam int GAP_COLS  = 1;

  typedef struct {
    logic [ROWS-1:0] pat;
    logic            ge;
  } col_t;

  typedef struct {
    logic [ROWS-1:0] pat;
    logic            ge;
    logic [ROWS-1:0] exp_leds;
    logic            exp_busy;
  } vec_t;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic loop_drv = 1'b0;

  always #5 clk = ~clk;

  pov_column_scanner_if #(.ROWS(ROWS), .DEPTH(DEPTH)) col_if ();

  pov_column_scanner #(
    .ROWS(ROWS), .DEPTH(DEPTH), .COL_TICKS(COL_TICKS), .GAP_COLS(GAP_COLS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .col_if (col_if)
  );

`ifdef POV_LOOP_EN
  assign col_if.loop_en = loop_drv;
`endif

  int total = 0;
  int bad   = 0;

  // Model: stored columns, display phase and what the LEDs currently show.
  col_t            mq[$];
  int              m_k       = 0;
  int              m_di      = 0;
  int              m_pending = 0;
  int              m_kind    = 0;   // 0 nothing shown, 1 data column, 2 gap column
  logic [ROWS-1:0] m_leds    = '0;
  logic            m_strobe  = 1'b0;
  logic            m_busy    = 1'b0;
  logic            m_uf      = 1'b0;
  logic            m_loop    = 1'b0;

  bit ord_en   = 1'b0;
  int ord_next = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit next_tick();
    return (m_k % COL_TICKS) == COL_TICKS - 1;
  endfunction

  task automatic model_edge(input logic v, input logic [ROWS-1:0] pat, input logic ge,
                            input logic rst, input logic lp);
    int   sz;
    bit   tk;
    bit   fall;
    col_t c;
    if (rst) begin
      mq.delete();
      m_k = 0; m_di = 0; m_pending = 0; m_kind = 0;
      m_leds = '0; m_strobe = 1'b0; m_busy = 1'b0; m_uf = 1'b0; m_loop = 1'b0;
      return;
    end
    sz   = mq.size();
    tk   = next_tick();
    m_k++;
    fall   = m_loop && !lp;
    m_loop = lp;
    m_strobe = tk;
    if (fall) begin
      mq.delete();
      m_di = 0; m_pending = 0; m_kind = 0; m_leds = '0; m_busy = 1'b0;
      return;
    end
    if (tk) begin
      if (m_pending > 0) begin
        m_pending--;
        m_leds = '0;
        m_kind = 2;
      end else if (sz > 0) begin
        if (lp) begin
          c    = mq[m_di];
          m_di = (m_di + 1 == sz) ? 0 : m_di + 1;
        end else begin
          c = mq.pop_front();
        end
        m_leds    = c.pat;
        m_kind    = 1;
        m_pending = c.ge ? GAP_COLS : 0;
      end else begin
        if (m_kind == 1 && !lp) m_uf = 1'b1;
        m_leds = '0;
        m_kind = 0;
      end
      m_busy = (m_kind != 0);
    end
    if (v && sz < DEPTH) mq.push_back('{pat: pat, ge: ge});
  endtask

  task automatic compare_all();
    check("leds",       32'(col_if.leds),       32'(m_leds));
    check("col_strobe", 32'(col_if.col_strobe), 32'(m_strobe));
    check("busy",       32'(col_if.busy),       32'(m_busy));
    check("underflow",  32'(col_if.underflow),  32'(m_uf));
    check("count",      32'(col_if.count),      32'(mq.size()));
    check("col_ready",  32'(col_if.col_ready),  32'(mq.size() < DEPTH));
    if (ord_en && col_if.col_strobe && col_if.leds != '0) begin
      check("order", 32'(col_if.leds), 32'h40 + 32'(ord_next));
      ord_next++;
    end
  endtask

  task automatic step(input logic v, input logic [ROWS-1:0] pat, input logic ge, input logic rst);
    col_if.col_valid     = v;
    col_if.input_pattern = pat;
    col_if.glyph_end     = ge;
    reset                = rst;
    @(posedge clk);
    model_edge(v, pat, ge, rst, loop_drv);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS-1:0] m_cols [7];
    logic [ROWS-1:0] a_cols [7];
    vec_t            tbl [9];
    int              idx;
    int              n;
    int              f8n;
    int              rate;
    bit              hit;
    bit              nt;

    col_if.col_valid     = 1'b0;
    col_if.input_pattern = '0;
    col_if.glyph_end     = 1'b0;
    @(negedge clk);

    // Reset values
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_leds",   32'(col_if.leds),       32'h0);
    check("rst_count",  32'(col_if.count),      32'h0);
    check("rst_ready",  32'(col_if.col_ready),  32'h1);
    check("rst_busy",   32'(col_if.busy),       32'h0);
    check("rst_uf",     32'(col_if.underflow),  32'h0);
    check("rst_strobe", 32'(col_if.col_strobe), 32'h0);

    // "M" glyph: seven columns, one gap column, then idle
    m_cols = '{8'hFF, 8'h02, 8'h04, 8'h08, 8'h04, 8'h02, 8'hFF};
    for (int i = 0; i < 7; i++)
      tbl[i] = '{pat: m_cols[i], ge: (i == 6), exp_leds: m_cols[i], exp_busy: 1'b1};
    tbl[7] = '{pat: '0, ge: 1'b0, exp_leds: '0, exp_busy: 1'b1};
    tbl[8] = '{pat: '0, ge: 1'b0, exp_leds: '0, exp_busy: 1'b0};
    idx = 0;
    n   = 0;
    for (int c = 0; c < 12 * COL_TICKS && idx < 9; c++) begin
      if (n < 7) begin
        step(1'b1, tbl[n].pat, tbl[n].ge, 1'b0);
        n++;
      end else begin
        step(1'b0, '0, 1'b0, 1'b0);
      end
      if (col_if.col_strobe) begin
        check($sformatf("m_leds[%0d]", idx), 32'(col_if.leds), 32'(tbl[idx].exp_leds));
        check($sformatf("m_busy[%0d]", idx), 32'(col_if.busy), 32'(tbl[idx].exp_busy));
        idx++;
      end
    end
    check("m_all_cols", 32'(idx), 32'd9);
    check("m_uf",       32'(col_if.underflow), 32'h0);

    // Fill to full, drop a write while full, drain in order across pointer wrap
    step(1'b0, '0, 1'b0, 1'b1);
    ord_en   = 1'b1;
    ord_next = 0;
    n        = 0;
    for (int c = 0; c < 200; c++) begin
      if (!col_if.col_ready && !next_tick()) break;
      if (col_if.col_ready) begin
        step(1'b1, ROWS'(32'h40 + 32'(n)), 1'b0, 1'b0);
        n++;
      end else begin
        step(1'b0, '0, 1'b0, 1'b0);
      end
    end
    check("full_count", 32'(col_if.count),     32'd16);
    check("full_ready", 32'(col_if.col_ready), 32'h0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("full_drop_count", 32'(col_if.count),     32'd16);
    check("full_drop_ready", 32'(col_if.col_ready), 32'h0);
    for (int c = 0; c < (DEPTH + 4) * COL_TICKS; c++) step(1'b0, '0, 1'b0, 1'b0);
    check("full_all_shown", 32'(ord_next), 32'(n));
    check("full_end_uf",    32'(col_if.underflow), 32'h1);
    ord_en = 1'b0;

    // Underflow after three columns without glyph_end
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int c = 0; c < 4 * COL_TICKS; c++) step(1'b0, '0, 1'b0, 1'b0);
    check("uf_leds", 32'(col_if.leds),      32'h0);
    check("uf_set",  32'(col_if.underflow), 32'h1);
    check("uf_idle", 32'(col_if.busy),      32'h0);
    for (int c = 0; c < 2 * COL_TICKS; c++) step(1'b0, '0, 1'b0, 1'b0);
    check("uf_sticky", 32'(col_if.underflow), 32'h1);

    // Reset mid-SHOW with four columns buffered (underflow still set from above)
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (col_if.busy && col_if.count == 4) begin
        hit = 1'b1;
        break;
      end
      step(col_if.count < 4, ROWS'(32'h70 + 32'(c)), 1'b0, 1'b0);
    end
    check("mid_reached", 32'(hit), 32'h1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("mid_leds",  32'(col_if.leds),      32'h0);
    check("mid_count", 32'(col_if.count),     32'h0);
    check("mid_busy",  32'(col_if.busy),      32'h0);
    check("mid_uf",    32'(col_if.underflow), 32'h0);

    // Simultaneous write and pop at count=5
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      nt = next_tick();
      if (nt && col_if.count == 5) begin
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        check("simul_count", 32'(col_if.count), 32'd5);
        hit = 1'b1;
        break;
      end
      step(!nt && col_if.count < 5, ROWS'(32'h60 + 32'(c)), 1'b0, 1'b0);
    end
    check("simul_reached", 32'(hit), 32'h1);

    // Write into an empty FIFO on a tick edge: shown one column period later
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < COL_TICKS && !next_tick(); c++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("etick_strobe", 32'(col_if.col_strobe), 32'h1);
    check("etick_leds",   32'(col_if.leds),       32'h0);
    hit = 1'b0;
    for (int c = 0; c < COL_TICKS + 1; c++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (col_if.col_strobe) begin
        hit = 1'b1;
        break;
      end
    end
    check("etick_next_tick", 32'(hit), 32'h1);
    check("etick_shown", 32'(col_if.leds), 32'h5A);

    // Random traffic against the model
    step(1'b0, '0, 1'b0, 1'b1);
    rate = 50;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) rate = int'($urandom_range(10, 95));
      step(int'($urandom_range(0, 99)) < rate, ROWS'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 299) == 0);
    end

`ifdef POV_LOOP_EN
    // Loop mode: "A" repeats with its gap; dropping loop_en clears the FIFO
    step(1'b0, '0, 1'b0, 1'b1);
    loop_drv = 1'b1;
    a_cols = '{8'hF8, 8'h0C, 8'h0A, 8'h09, 8'h0A, 8'h0C, 8'hF8};
    for (int i = 0; i < 7; i++) step(1'b1, a_cols[i], (i == 6), 1'b0);
    f8n = 0;
    for (int c = 0; c < 4 * 8 * COL_TICKS; c++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (col_if.col_strobe && col_if.leds == 8'hF8) f8n++;
    end
    check("loop_repeats", 32'(f8n >= 6), 32'h1);
    check("loop_count",   32'(col_if.count),     32'd7);
    check("loop_uf",      32'(col_if.underflow), 32'h0);
    loop_drv = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    check("unloop_count", 32'(col_if.count), 32'h0);
    check("unloop_leds",  32'(col_if.leds),  32'h0);
    check("unloop_busy",  32'(col_if.busy),  32'h0);
    for (int c = 0; c < 2 * COL_TICKS; c++) step(1'b0, '0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
